// File: rtl/dest_forward_pipe.sv
// dest_forward_pipe: EX/MEM and MEM/WB destination tracking, register-file
// write port, operand-forwarding selects and load-use hazard detection.
module dest_forward_pipe #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] ex_dest,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic [DW-1:0] ex_result,
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    fwd_a_sel,
    output logic [1:0]    fwd_b_sel,
    output logic [DW-1:0] fwd_mem_data,
    output logic [DW-1:0] fwd_wb_data,
    output logic          load_use,
    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // EX/MEM pipeline register
    logic [AW-1:0] mem_dest;
    logic          mem_regwrite;
    logic          mem_memread;
    logic [DW-1:0] mem_result;

    // MEM/WB pipeline register
    logic [AW-1:0] wb_dest;
    logic          wb_regwrite;
    logic [DW-1:0] wb_data_q;

    // Qualified forwarding sources
    logic          mem_fwd_ok;
    logic          wb_fwd_ok;

    // EX/MEM register: stall holds, flush inserts a bubble, else capture EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_dest     <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_result   <= '0;
        end else if (!stall) begin
            if (flush) begin
                mem_dest     <= '0;
                mem_regwrite <= 1'b0;
                mem_memread  <= 1'b0;
                mem_result   <= '0;
            end else begin
                mem_dest     <= ex_dest;
                mem_regwrite <= ex_regwrite;
                mem_memread  <= ex_memread;
                mem_result   <= ex_result;
            end
        end
    end

    // MEM/WB register: loads pick memory read data, everything else the ALU result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_dest     <= '0;
            wb_regwrite <= 1'b0;
            wb_data_q   <= '0;
        end else if (!stall) begin
            wb_dest     <= mem_dest;
            wb_regwrite <= mem_regwrite;
            wb_data_q   <= mem_memread ? mem_rdata : mem_result;
        end
    end

    // A load in MEM has no data yet, so it is never a MEM forwarding source
    assign mem_fwd_ok = mem_regwrite && !mem_memread && (mem_dest != '0);
    assign wb_fwd_ok  = wb_regwrite && (wb_dest != '0);

    // Operand A select: the younger MEM producer shadows WB
    always_comb begin
        fwd_a_sel = SEL_RF;
        if (mem_fwd_ok && (mem_dest == ex_rs)) begin
            fwd_a_sel = SEL_MEM;
        end else if (wb_fwd_ok && (wb_dest == ex_rs)) begin
            fwd_a_sel = SEL_WB;
        end
    end

    // Operand B select: the younger MEM producer shadows WB
    always_comb begin
        fwd_b_sel = SEL_RF;
        if (mem_fwd_ok && (mem_dest == ex_rt)) begin
            fwd_b_sel = SEL_MEM;
        end else if (wb_fwd_ok && (wb_dest == ex_rt)) begin
            fwd_b_sel = SEL_WB;
        end
    end

    // Load in EX feeding the ID instruction needs a one-cycle bubble
    assign load_use = ex_memread && (ex_dest != '0) &&
                      ((ex_dest == id_rs) || (ex_dest == id_rt));

    // Register-file write port; r0 is hardwired and never written
    assign wb_we        = wb_regwrite && (wb_dest != '0);
    assign wb_addr      = wb_dest;
    assign wb_data      = wb_data_q;
    assign fwd_mem_data = mem_result;
    assign fwd_wb_data  = wb_data_q;

endmodule

// File: tb/tb_dest_forward_pipe.sv
// Bench for dest_forward_pipe: directed scenarios plus randomized traffic
// checked against a stage-record model of the pipeline.
module tb_dest_forward_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush;
    logic [AW-1:0] ex_dest, ex_rs, ex_rt, id_rs, id_rt;
    logic          ex_regwrite, ex_memread;
    logic [DW-1:0] ex_result, mem_rdata;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [DW-1:0] fwd_mem_data, fwd_wb_data, wb_data;
    logic          load_use, wb_we;
    logic [AW-1:0] wb_addr;

    int total = 0;
    int bad   = 0;

    // Model: one record per occupied stage
    typedef struct {
        int unsigned dest;
        bit          rw;
        bit          ld;
        int unsigned val;
    } stage_t;

    stage_t m_mem, m_wb;

    dest_forward_pipe #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_result(ex_result), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .mem_rdata(mem_rdata),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .load_use(load_use), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    function automatic stage_t empty_stage();
        stage_t s;
        s.dest = 0; s.rw = 0; s.ld = 0; s.val = 0;
        return s;
    endfunction

    task automatic model_reset();
        m_mem = empty_stage();
        m_wb  = empty_stage();
    endtask

    // Advance the model by one clock edge using the inputs present at the edge
    task automatic model_edge();
        stage_t nm;
        if (rst) begin
            model_reset();
        end else if (!stall) begin
            m_wb.dest = m_mem.dest;
            m_wb.rw   = m_mem.rw;
            m_wb.ld   = 0;
            m_wb.val  = m_mem.ld ? int'(mem_rdata) : m_mem.val;
            nm = empty_stage();
            if (!flush) begin
                nm.dest = int'(ex_dest);
                nm.rw   = ex_regwrite;
                nm.ld   = ex_memread;
                nm.val  = int'(ex_result);
            end
            m_mem = nm;
        end
    endtask

    // Expected forwarding select for one source register
    function automatic logic [1:0] exp_sel(int unsigned src);
        if (m_mem.rw && !m_mem.ld && m_mem.dest != 0 && m_mem.dest == src) return 2'b10;
        if (m_wb.rw && m_wb.dest != 0 && m_wb.dest == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        stall = 0; flush = 0;
        ex_dest = '0; ex_regwrite = 0; ex_memread = 0; ex_result = '0;
        ex_rs = '0; ex_rt = '0; id_rs = '0; id_rt = '0; mem_rdata = '0;
    endtask

    task automatic instr(input int unsigned d, input bit rw, input bit ld, input int unsigned v);
        ex_dest = AW'(d); ex_regwrite = rw; ex_memread = ld; ex_result = DW'(v);
    endtask

    // One clock edge, model kept in step, sampling point 1ns after the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        model_reset();
        #12;
        total += 7;
        if (wb_we !== 1'b0)   begin bad++; $display("FAIL reset_we got=%b want=0", wb_we); end
        if (wb_addr !== '0)   begin bad++; $display("FAIL reset_addr got=%0d want=0", wb_addr); end
        if (wb_data !== '0)   begin bad++; $display("FAIL reset_data got=%h want=0", wb_data); end
        if (fwd_mem_data !== '0) begin bad++; $display("FAIL reset_fmem got=%h want=0", fwd_mem_data); end
        if (fwd_wb_data !== '0)  begin bad++; $display("FAIL reset_fwb got=%h want=0", fwd_wb_data); end
        if (fwd_a_sel !== 2'b00) begin bad++; $display("FAIL reset_sela got=%b want=00", fwd_a_sel); end
        if (fwd_b_sel !== 2'b00) begin bad++; $display("FAIL reset_selb got=%b want=00", fwd_b_sel); end
        @(negedge clk);
        rst = 0;
        // Put a write into WB, then reset asynchronously mid-cycle
        instr(9, 1, 0, 32'hDEAD_BEEF);
        tick();
        idle();
        tick();
        total++;
        if (wb_we !== 1'b1) begin bad++; $display("FAIL pre_reset_we got=%b want=1", wb_we); end
        #2;
        rst = 1;
        model_reset();
        #1;
        total += 3;
        if (wb_we !== 1'b0) begin bad++; $display("FAIL async_reset_we got=%b want=0", wb_we); end
        if (wb_data !== '0) begin bad++; $display("FAIL async_reset_data got=%h want=0", wb_data); end
        if (wb_addr !== '0) begin bad++; $display("FAIL async_reset_addr got=%0d want=0", wb_addr); end
        @(negedge clk);
        rst = 0;
        instr(12, 1, 0, 32'h0000_0C0C);
        tick();
        idle();
        total++;
        if (wb_we !== 1'b0) begin bad++; $display("FAIL post_reset_edge1_we got=%b want=0", wb_we); end
        tick();
        total += 3;
        if (wb_we !== 1'b1) begin bad++; $display("FAIL post_reset_edge2_we got=%b want=1", wb_we); end
        if (wb_addr !== 5'd12) begin bad++; $display("FAIL post_reset_addr got=%0d want=12", wb_addr); end
        if (wb_data !== 32'h0000_0C0C) begin bad++; $display("FAIL post_reset_data got=%h want=c0c", wb_data); end
    endtask

    task automatic test_basic_write();
        idle();
        instr(5, 1, 0, 32'h1234);
        tick();
        idle();
        tick();
        total += 3;
        if (wb_we !== 1'b1)      begin bad++; $display("FAIL basic_we got=%b want=1", wb_we); end
        if (wb_addr !== 5'd5)    begin bad++; $display("FAIL basic_addr got=%0d want=5", wb_addr); end
        if (wb_data !== 32'h1234) begin bad++; $display("FAIL basic_data got=%h want=1234", wb_data); end
        instr(0, 1, 0, 32'h5678);
        tick();
        idle();
        tick();
        total++;
        if (wb_we !== 1'b0) begin bad++; $display("FAIL r0_we got=%b want=0", wb_we); end
    endtask

    task automatic test_forwarding();
        idle();
        // Adjacent producer: forward from MEM
        instr(3, 1, 0, 32'hAA);
        tick();
        idle();
        ex_rs = 5'd3; ex_rt = 5'd3;
        #1;
        total += 3;
        if (fwd_a_sel !== 2'b10) begin bad++; $display("FAIL fwd_mem_sela got=%b want=10", fwd_a_sel); end
        if (fwd_b_sel !== 2'b10) begin bad++; $display("FAIL fwd_mem_selb got=%b want=10", fwd_b_sel); end
        if (fwd_mem_data !== 32'hAA) begin bad++; $display("FAIL fwd_mem_data got=%h want=aa", fwd_mem_data); end
        tick();
        // One unrelated instruction between: forward from WB
        idle();
        instr(3, 1, 0, 32'hAA);
        tick();
        instr(9, 1, 0, 32'h99);
        tick();
        idle();
        ex_rs = 5'd3; ex_rt = 5'd3;
        #1;
        total += 3;
        if (fwd_a_sel !== 2'b01) begin bad++; $display("FAIL fwd_wb_sela got=%b want=01", fwd_a_sel); end
        if (fwd_b_sel !== 2'b01) begin bad++; $display("FAIL fwd_wb_selb got=%b want=01", fwd_b_sel); end
        if (fwd_wb_data !== 32'hAA) begin bad++; $display("FAIL fwd_wb_data got=%h want=aa", fwd_wb_data); end
        tick();
        // Both stages write r3: MEM shadows WB
        idle();
        instr(3, 1, 0, 32'h1);
        tick();
        instr(3, 1, 0, 32'h2);
        tick();
        idle();
        ex_rs = 5'd3; ex_rt = 5'd3;
        #1;
        total += 4;
        if (fwd_a_sel !== 2'b10) begin bad++; $display("FAIL shadow_sela got=%b want=10", fwd_a_sel); end
        if (fwd_b_sel !== 2'b10) begin bad++; $display("FAIL shadow_selb got=%b want=10", fwd_b_sel); end
        if (fwd_mem_data !== 32'h2) begin bad++; $display("FAIL shadow_mem got=%h want=2", fwd_mem_data); end
        if (fwd_wb_data !== 32'h1)  begin bad++; $display("FAIL shadow_wb got=%h want=1", fwd_wb_data); end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        instr(7, 1, 1, 32'h0);
        id_rt = 5'd7;
        #1;
        total++;
        if (load_use !== 1'b1) begin bad++; $display("FAIL load_use_hit got=%b want=1", load_use); end
        ex_dest = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        total++;
        if (load_use !== 1'b0) begin bad++; $display("FAIL load_use_r0 got=%b want=0", load_use); end
        ex_dest = 5'd7;
        tick();
        // Load in MEM: bubble cycle, must not forward from MEM
        idle();
        mem_rdata = 32'h55;
        ex_rs = 5'd7;
        #1;
        total++;
        if (fwd_a_sel !== 2'b00) begin bad++; $display("FAIL load_in_mem_sel got=%b want=00", fwd_a_sel); end
        tick();
        idle();
        ex_rs = 5'd7;
        #1;
        total += 4;
        if (fwd_a_sel !== 2'b01) begin bad++; $display("FAIL load_wb_sel got=%b want=01", fwd_a_sel); end
        if (fwd_wb_data !== 32'h55) begin bad++; $display("FAIL load_fwd_data got=%h want=55", fwd_wb_data); end
        if (wb_data !== 32'h55) begin bad++; $display("FAIL load_wb_data got=%h want=55", wb_data); end
        if (wb_we !== 1'b1) begin bad++; $display("FAIL load_wb_we got=%b want=1", wb_we); end
        tick();
    endtask

    task automatic test_stall_flush();
        idle();
        instr(4, 1, 0, 32'h44);
        tick();
        instr(6, 1, 0, 32'h66);
        tick();
        // Stall three cycles with a new instruction waiting in EX
        instr(8, 1, 0, 32'h88);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total += 4;
            if (wb_we !== 1'b1) begin bad++; $display("FAIL stall%0d_we got=%b want=1", i, wb_we); end
            if (wb_addr !== 5'd4) begin bad++; $display("FAIL stall%0d_addr got=%0d want=4", i, wb_addr); end
            if (wb_data !== 32'h44) begin bad++; $display("FAIL stall%0d_data got=%h want=44", i, wb_data); end
            if (fwd_mem_data !== 32'h66) begin bad++; $display("FAIL stall%0d_mem got=%h want=66", i, fwd_mem_data); end
        end
        idle();
        tick();
        total++;
        if (wb_addr !== 5'd6) begin bad++; $display("FAIL unstall_addr got=%0d want=6", wb_addr); end
        // Flush turns the EX instruction into a bubble
        instr(10, 1, 0, 32'hAB);
        flush = 1;
        tick();
        idle();
        total++;
        if (fwd_mem_data !== '0) begin bad++; $display("FAIL flush_mem got=%h want=0", fwd_mem_data); end
        tick();
        total++;
        if (wb_we !== 1'b0) begin bad++; $display("FAIL flush_we got=%b want=0", wb_we); end
        // Stall wins over flush
        instr(11, 1, 0, 32'hBB);
        tick();
        instr(12, 1, 0, 32'hCC);
        stall = 1; flush = 1;
        tick();
        total++;
        if (fwd_mem_data !== 32'hBB) begin bad++; $display("FAIL stallflush_mem got=%h want=bb", fwd_mem_data); end
        idle();
        tick();
        total += 3;
        if (wb_we !== 1'b1) begin bad++; $display("FAIL stallflush_we got=%b want=1", wb_we); end
        if (wb_addr !== 5'd11) begin bad++; $display("FAIL stallflush_addr got=%0d want=11", wb_addr); end
        if (wb_data !== 32'hBB) begin bad++; $display("FAIL stallflush_data got=%h want=bb", wb_data); end
    endtask

    task automatic test_random();
        logic          e_we, e_lu;
        logic [1:0]    e_sa, e_sb;
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 99) < 3);
            stall       = ($urandom_range(0, 99) < 15);
            flush       = ($urandom_range(0, 99) < 10);
            ex_dest     = AW'($urandom_range(0, 7));
            ex_regwrite = ($urandom_range(0, 99) < 75);
            ex_memread  = ($urandom_range(0, 99) < 30);
            ex_result   = $urandom;
            mem_rdata   = $urandom;
            ex_rs       = AW'($urandom_range(0, 7));
            ex_rt       = AW'($urandom_range(0, 7));
            id_rs       = AW'($urandom_range(0, 7));
            id_rt       = AW'($urandom_range(0, 7));
            if (rst) model_reset();
            #1;
            e_we = m_wb.rw && m_wb.dest != 0;
            e_sa = exp_sel(int'(ex_rs));
            e_sb = exp_sel(int'(ex_rt));
            e_lu = ex_memread && ex_dest != 0 && (ex_dest == id_rs || ex_dest == id_rt);
            total += 8;
            if (wb_we !== e_we) begin bad++; $display("FAIL rnd%0d_we got=%b want=%b", n, wb_we, e_we); end
            if (wb_addr !== AW'(m_wb.dest)) begin bad++; $display("FAIL rnd%0d_addr got=%0d want=%0d", n, wb_addr, m_wb.dest); end
            if (wb_data !== DW'(m_wb.val)) begin bad++; $display("FAIL rnd%0d_data got=%h want=%h", n, wb_data, m_wb.val); end
            if (fwd_wb_data !== DW'(m_wb.val)) begin bad++; $display("FAIL rnd%0d_fwb got=%h want=%h", n, fwd_wb_data, m_wb.val); end
            if (fwd_mem_data !== DW'(m_mem.val)) begin bad++; $display("FAIL rnd%0d_fmem got=%h want=%h", n, fwd_mem_data, m_mem.val); end
            if (fwd_a_sel !== e_sa) begin bad++; $display("FAIL rnd%0d_sela got=%b want=%b", n, fwd_a_sel, e_sa); end
            if (fwd_b_sel !== e_sb) begin bad++; $display("FAIL rnd%0d_selb got=%b want=%b", n, fwd_b_sel, e_sb); end
            if (load_use !== e_lu) begin bad++; $display("FAIL rnd%0d_lu got=%b want=%b", n, load_use, e_lu); end
            tick();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_forwarding();
        test_load_use();
        test_stall_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dest_forward_pipe.md
# dest_forward_pipe

Downstream consumer of the 5-bit destination-register mux in the EX stage. It carries each instruction's destination address, write-enable, load flag and result through the EX/MEM and MEM/WB pipeline registers. It drives the register-file write port and generates operand-forwarding selects and the load-use hazard flag. It is the single owner of "who writes which register, and when" in the 5-stage pipeline.

## Interface

Parameters:
- DW, 32, datapath width of results and load data
- AW, 5, register address width (matches the destination mux output)

Ports:
- clk  input  1  single pipeline clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- stall  input  1  global freeze; MEM and WB registers hold
- flush  input  1  load a bubble into the MEM register
- ex_dest  input  AW  selected destination address of the instruction in EX
- ex_regwrite  input  1  EX instruction writes a register
- ex_memread  input  1  EX instruction is a load
- ex_result  input  DW  ALU result of the EX instruction
- ex_rs, ex_rt  input  AW  source addresses of the EX instruction (forwarding compare)
- id_rs, id_rt  input  AW  source addresses of the ID instruction (hazard compare)
- mem_rdata  input  DW  data-memory read data for the MEM instruction
- fwd_a_sel, fwd_b_sel  output  2  00 regfile, 10 from MEM, 01 from WB
- fwd_mem_data  output  DW  MEM-stage result
- fwd_wb_data  output  DW  WB-stage write data
- load_use  output  1  stall request for the ID instruction
- wb_we  output  1  register-file write enable
- wb_addr  output  AW  register-file write address
- wb_data  output  DW  register-file write data

## Operation

- MEM register {dest, regwrite, memread, result}:
  - loads ex_* each rising edge when stall=0;
  - when flush=1 and stall=0, loads regwrite=0, memread=0, dest=0, result=0.
- WB register {dest, regwrite, data}:
  - loads from MEM each edge when stall=0;
  - data = mem_memread ? mem_rdata : mem_result, sampled at the edge.
- stall=1 holds both registers. stall has priority over flush.
- wb_we = wb_regwrite && wb_dest != 0. Register 0 is never written.
- wb_addr = wb_dest; wb_data = WB data register.
- Forwarding, per operand X in {rs→a, rt→b}:
  - sel=10 when mem_regwrite && !mem_memread && mem_dest!=0 && mem_dest==ex_X;
  - else sel=01 when wb_regwrite && wb_dest!=0 && wb_dest==ex_X;
  - else 00.
  - MEM beats WB when both match.
- fwd_mem_data = MEM result register; fwd_wb_data = WB data register.
- load_use = ex_memread && ex_dest!=0 && (ex_dest==id_rs || ex_dest==id_rt). Purely combinational on inputs. Upstream turns it into a bubble.
- A load in MEM is never forwarded from MEM: load_use has already stalled that case by one cycle, so the value arrives via WB.

## Timing

- Reset (async, immediate): all MEM/WB register fields go to 0.
  - Outputs during reset: wb_we=0, wb_addr=0, wb_data=0, fwd_mem_data=0, fwd_wb_data=0, fwd_*_sel=00.
  - load_use follows its inputs.
- Reset released mid-stream: pipeline restarts empty. No write issues from any pre-reset instruction.
- Latency:
  - EX inputs are visible as MEM state 1 cycle after the edge.
  - The regfile write (wb_we) is asserted during the 2nd cycle.
  - The write commits at the regfile's following edge.
- Forward selects and load_use are combinational, stable before the next rising edge.
- Back-to-back writes to the same register: each is written in order; MEM forwarding shadows WB.
- stall held N cycles: wb_we stays at its held value and rewrites the same data (idempotent). No MEM→WB advance.

## Test plan

- Reset: assert rst asynchronously mid-cycle with a write in WB -> wb_we drops to 0 immediately; all outputs 0; first post-reset instruction reaches wb_we on the 2nd edge.
- Basic write: ex_dest=5, regwrite=1, result=0x1234 -> after 2 edges wb_we=1, wb_addr=5, wb_data=0x1234; ex_dest=0 case gives wb_we=0.
- Forwarding: instr A writes r3 = 0xAA, instr B has ex_rs=3, ex_rt=3:
  - next cycle fwd_a_sel=fwd_b_sel=10, fwd_mem_data=0xAA;
  - with one unrelated instr between them, sel=01 and fwd_wb_data=0xAA;
  - with both A(r3=1) in WB and C(r3=2) in MEM, sel=10 and the value is 2.
- Load-use: ex_memread=1, ex_dest=7, id_rt=7 -> load_use=1; id_rs=id_rt=0 with ex_dest=0 -> load_use=0. Load data mem_rdata=0x55 reaches wb_data, and sel=01 for the dependent instruction.
- Stall/flush:
  - stall=1 for 3 cycles -> MEM/WB unchanged;
  - flush=1 -> next cycle the MEM bubble produces wb_we=0 one cycle later;
  - stall=1 with flush=1 -> hold, no bubble.
